layer_sequencer: RTL and testbench

//  Multi-layer controller for the 4-lane neuron array and its inter-layer

---
 rtl/lseq_pkg.sv | 16 +
 rtl/lane_collect.sv | 49 ++++
 rtl/layer_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_layer_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lseq_pkg.sv
// Shared definitions for the layer sequencer: FSM state encoding and lane/data sizing.
package lseq_pkg;

   localparam int DATA_W = 8;
   localparam int NLANES = 4;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LAUNCH  = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [NLANES-1:0] lane_mask_t;

endpackage

// File: rtl/lane_collect.sv
// One neuron lane's completion tracker: a sticky done flag plus the first result
// captured while collection is enabled; later ready pulses are ignored.
module lane_collect
   import lseq_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  clr_i,
   input  logic  en_i,
   input  logic  rdy_i,
   input  data_t dat_i,
   input  logic  zero_i,
   output logic  flag_o,
   output data_t res_o
);

   logic  flag_q, flag_d;
   data_t res_q, res_d;

   always_comb begin
      flag_d = flag_q;
      res_d  = res_q;
      if (clr_i) begin
         flag_d = 1'b0;
      end else if (en_i && !flag_q) begin
         // A lane reporting in the same cycle as a forced close still keeps its value
         if (rdy_i) begin
            flag_d = 1'b1;
            res_d  = dat_i;
         end else if (zero_i) begin
            res_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_q <= 1'b0;
         res_q  <= '0;
      end else begin
         flag_q <= flag_d;
         res_q  <= res_d;
      end
   end

   assign flag_o = flag_q;
   assign res_o  = res_q;

endmodule

// File: rtl/layer_sequencer.sv
// Multi-layer controller for the 4-lane neuron array: fires one array pass per layer,
// chains each layer's outputs into the next, and hands out the final vector.
// Optional watchdog on the lane wait is enabled by defining LSEQ_TIMEOUT_EN.
module layer_sequencer
   import lseq_pkg::*;
#(
   parameter int NUM_LAYERS = 3,
   parameter int LW         = 2,
   parameter int TMO_CYC    = 255
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in1,
   input  logic [7:0]    in2,
   input  logic [7:0]    in3,
   input  logic [7:0]    in4,
   output logic          neu_new,
   output logic [7:0]    neu_in1,
   output logic [7:0]    neu_in2,
   output logic [7:0]    neu_in3,
   output logic [7:0]    neu_in4,
   output logic [LW-1:0] layer_sel,
   input  logic          neu_ready1,
   input  logic          neu_ready2,
   input  logic          neu_ready3,
   input  logic          neu_ready4,
   input  logic [7:0]    neu_out1,
   input  logic [7:0]    neu_out2,
   input  logic [7:0]    neu_out3,
   input  logic [7:0]    neu_out4,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out1,
   output logic [7:0]    out2,
   output logic [7:0]    out3,
   output logic [7:0]    out4,
   output logic          busy,
   output logic          err
);

   localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

   logic [2:0]               state_q, state_d;
   logic [LW-1:0]            layer_q, layer_d;
   data_t [NLANES-1:0]       work_q, work_d;
   logic                     neu_new_q;

   lane_mask_t               rdy_vec, flag_vec, done_nxt;
   data_t [NLANES-1:0]       nout_vec, res_vec;
   logic                     in_wait, clr_lanes, tmo_hit;

   assign rdy_vec   = {neu_ready4, neu_ready3, neu_ready2, neu_ready1};
   assign nout_vec  = {neu_out4, neu_out3, neu_out2, neu_out1};
   assign in_wait   = (state_q == S_WAIT);
   assign clr_lanes = (state_q == S_LAUNCH);
   // Includes this cycle's readies so the layer closes the cycle the last lane reports
   assign done_nxt  = flag_vec | rdy_vec;

   for (genvar i = 0; i < NLANES; i++) begin : g_lane
      lane_collect u_lane (
         .clk    (clk),
         .rst    (rst),
         .clr_i  (clr_lanes),
         .en_i   (in_wait),
         .rdy_i  (rdy_vec[i]),
         .dat_i  (nout_vec[i]),
         .zero_i (tmo_hit),
         .flag_o (flag_vec[i]),
         .res_o  (res_vec[i])
      );
   end

`ifdef LSEQ_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

   logic [7:0] tmo_cnt_q, tmo_cnt_d;
   logic       err_q, err_d;

   assign tmo_hit = in_wait && (done_nxt != '1) && (tmo_cnt_q == TMO_LAST);

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      err_d     = err_q;
      if (clr_lanes) begin
         tmo_cnt_d = '0;
      end else if (in_wait) begin
         tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
      if (tmo_hit) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = (TMO_CYC != 0);
   assign tmo_hit        = 1'b0;
   assign err            = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      layer_d = layer_q;
      work_d  = work_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               work_d  = {in4, in3, in2, in1};
               layer_d = '0;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if ((done_nxt == '1) || tmo_hit) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            work_d = res_vec;
            if (layer_q == LAST_LAYER) begin
               state_d = S_DONE;
            end else begin
               layer_d = layer_q + 1'b1;
               state_d = S_LAUNCH;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // neu_new comes straight from a flop so a reset can only ever pull it low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         layer_q   <= '0;
         work_q    <= '0;
         neu_new_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         layer_q   <= layer_d;
         work_q    <= work_d;
         neu_new_q <= (state_d == S_LAUNCH);
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign neu_new   = neu_new_q;
   assign layer_sel = layer_q;

   assign neu_in1 = work_q[0];
   assign neu_in2 = work_q[1];
   assign neu_in3 = work_q[2];
   assign neu_in4 = work_q[3];

   assign out1 = work_q[0];
   assign out2 = work_q[1];
   assign out3 = work_q[2];
   assign out4 = work_q[3];

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: a behavioural neuron-array responder and a per-layer
// reference of the expected vector chain; watchdog scenario needs LSEQ_TIMEOUT_EN.
module tb_layer_sequencer;

   localparam int NL  = 3;
   localparam int TMO = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic [3:0][7:0]  vin = '0;
   logic [3:0]       nrdy = '0;
   logic [3:0][7:0]  nout = '0;
   logic             in_ready, neu_new, out_valid, busy, err;
   logic [3:0][7:0]  nin, outv;
   logic [1:0]       layer_sel;

   int   checks = 0;
   int   errors = 0;
   logic exp_err = 1'b0;

   always #5 clk = ~clk;

   layer_sequencer #(.NUM_LAYERS(NL), .LW(2), .TMO_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in1(vin[0]), .in2(vin[1]), .in3(vin[2]), .in4(vin[3]),
      .neu_new(neu_new),
      .neu_in1(nin[0]), .neu_in2(nin[1]), .neu_in3(nin[2]), .neu_in4(nin[3]),
      .layer_sel(layer_sel),
      .neu_ready1(nrdy[0]), .neu_ready2(nrdy[1]), .neu_ready3(nrdy[2]), .neu_ready4(nrdy[3]),
      .neu_out1(nout[0]), .neu_out2(nout[1]), .neu_out3(nout[2]), .neu_out4(nout[3]),
      .out_valid(out_valid), .out_ready(out_ready),
      .out1(outv[0]), .out2(outv[1]), .out3(outv[2]), .out4(outv[3]),
      .busy(busy), .err(err)
   );

   // What the neuron array computes for one lane in one layer
   function automatic logic [7:0] arr_fn(int fmode, int layer, int lane, logic [7:0] x);
      case (fmode)
         0:       return 8'(x + 1);
         1:       return 8'(5 + lane);
         default: return 8'(x * 3 + layer * 29 + lane * 7) ^ 8'hA5;
      endcase
   endfunction

   // Full inference: accept v, play the array for every layer, check the final handshake.
   // dmode 0: all lanes at +2; 1: staggered with a late re-pulse; 2: random delays.
   task automatic run_inf(input logic [3:0][7:0] v, input int fmode, input int dmode,
                          input int hold, input bit stuck3, input string tag);
      logic [3:0][7:0] cur, nxt;
      int d [4];
      int p2 [4];
      int dmax;
      cur = v;
      checks++;
      if ({in_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL %s idle got rdy/busy=%b want 10", tag, {in_ready, busy});
      end
      vin = v;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      vin = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      for (int k = 0; k < NL; k++) begin
         checks++;
         if ({neu_new, busy, out_valid, in_ready, layer_sel} !== {4'b1100, 2'(k)}) begin
            errors++;
            $display("FAIL %s launch L%0d got new/busy/ov/ir/sel=%b want %b", tag, k,
                     {neu_new, busy, out_valid, in_ready, layer_sel}, {4'b1100, 2'(k)});
         end
         checks++;
         if (nin !== cur) begin
            errors++;
            $display("FAIL %s neu_in L%0d got %h want %h", tag, k, nin, cur);
         end
         dmax = 0;
         for (int l = 0; l < 4; l++) begin
            p2[l] = 0;
            case (dmode)
               0:       d[l] = 2;
               1:       d[l] = (l == 0) ? 4 : (l == 2) ? 1 : 6;
               default: d[l] = int'($urandom_range(1, 6));
            endcase
            if (dmode == 1 && l == 0) p2[l] = 5;
            if (stuck3 && l == 3) d[l] = 1000;
            else if (d[l] > dmax) dmax = d[l];
            nxt[l] = (stuck3 && l == 3) ? 8'h00 : arr_fn(fmode, k, l, cur[l]);
         end
         if (stuck3) dmax = TMO;
         for (int t = 1; t <= dmax; t++) begin
            @(negedge clk);
            checks++;
            if ({neu_new, busy, out_valid, in_ready, layer_sel, nin} !== {4'b0100, 2'(k), cur}) begin
               errors++;
               $display("FAIL %s wait L%0d t=%0d got %b/%h want %b/%h", tag, k, t,
                        {neu_new, busy, out_valid, in_ready, layer_sel}, nin, {4'b0100, 2'(k)}, cur);
            end
            for (int l = 0; l < 4; l++) begin
               if (t == d[l]) begin
                  nrdy[l] = 1'b1;
                  nout[l] = nxt[l];
               end else if (t == p2[l]) begin
                  nrdy[l] = 1'b1;
                  nout[l] = 8'hFF;
               end else begin
                  nrdy[l] = 1'b0;
                  nout[l] = 8'($urandom);
               end
            end
         end
         @(negedge clk);
         nrdy = '0;
         if (stuck3) exp_err = 1'b1;
         checks++;
         if ({neu_new, busy, out_valid, err} !== {3'b010, exp_err}) begin
            errors++;
            $display("FAIL %s capture L%0d got new/busy/ov/err=%b want %b", tag, k,
                     {neu_new, busy, out_valid, err}, {3'b010, exp_err});
         end
         cur = nxt;
         @(negedge clk);
      end
      checks++;
      if ({out_valid, in_ready, busy, neu_new, err} !== {4'b1010, exp_err}) begin
         errors++;
         $display("FAIL %s done status got %b want %b", tag,
                  {out_valid, in_ready, busy, neu_new, err}, {4'b1010, exp_err});
      end
      checks++;
      if (outv !== cur) begin
         errors++;
         $display("FAIL %s result got %h want %h", tag, outv, cur);
      end
      if (hold > 0) begin
         in_valid = 1'b1;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, outv} !== {2'b10, cur}) begin
               errors++;
               $display("FAIL %s hold c%0d got ov/ir=%b out=%h want 10 %h", tag, h,
                        {out_valid, in_ready}, outv, cur);
            end
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (hold == 0) in_valid = 1'b0;
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         errors++;
         $display("FAIL %s release got ov/ir/busy=%b want 010", tag, {out_valid, in_ready, busy});
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, neu_new, out_valid, busy, err, layer_sel} !== 7'b1000000) begin
         errors++;
         $display("FAIL reset status got %b want 1000000",
                  {in_ready, neu_new, out_valid, busy, err, layer_sel});
      end
      checks++;
      if ({outv, nin} !== 64'h0) begin
         errors++;
         $display("FAIL reset data got %h/%h want 0", outv, nin);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single;
      run_inf({8'd4, 8'd3, 8'd2, 8'd1}, 1, 0, 0, 1'b0, "single");
   endtask

   task automatic test_chain;
      run_inf({8'd4, 8'd3, 8'd2, 8'd1}, 0, 2, 0, 1'b0, "chain");
   endtask

   task automatic test_stagger;
      run_inf({8'h9C, 8'h40, 8'h11, 8'hE7}, 2, 1, 0, 1'b0, "stagger");
   endtask

   task automatic test_back_to_back;
      run_inf({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 2, 2, 10, 1'b0, "hold");
      run_inf({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 0, 2, 0, 1'b0, "after_hold");
   endtask

   task automatic test_reset_mid;
      vin = {8'd8, 8'd7, 8'd6, 8'd5};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      nrdy = '1;
      nout = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      @(negedge clk);
      nrdy = '0;
      @(negedge clk);
      checks++;
      if ({neu_new, layer_sel} !== 3'b101) begin
         errors++;
         $display("FAIL rstmid launch L1 got new/sel=%b want 101", {neu_new, layer_sel});
      end
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, busy, neu_new, out_valid, layer_sel} !== 6'b100000) begin
         errors++;
         $display("FAIL rstmid async got ir/busy/new/ov/sel=%b want 100000",
                  {in_ready, busy, neu_new, out_valid, layer_sel});
      end
      checks++;
      if (nin !== 32'h0) begin
         errors++;
         $display("FAIL rstmid data got %h want 0", nin);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_err = 1'b0;
      @(negedge clk);
      run_inf({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 2, 2, 0, 1'b0, "post_rst");
   endtask

   task automatic test_random;
      for (int i = 0; i < 8; i++) begin
         run_inf({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)},
                 int'($urandom_range(0, 2)), 2, int'($urandom_range(0, 3)), 1'b0, "random");
      end
   endtask

`ifdef LSEQ_TIMEOUT_EN
   task automatic test_timeout;
      run_inf({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 2, 2, 0, 1'b1, "timeout");
      @(negedge clk);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL timeout sticky err got %b want 1", err);
      end
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_single;
      test_chain;
      test_stagger;
      test_back_to_back;
      test_reset_mid;
      test_random;
`ifdef LSEQ_TIMEOUT_EN
      test_timeout;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
